drt_lookup_ctrl: RTL and testbench

Wishbone master controller that walks the device ROM table (DRT) and looks up one device by its 32-bit ID word. On `start` it reads the DRT header, checks the DRT ID, reads the device count, then scans the 4-word device entries in order. On a match it fetches that entry's info, memory offset and size words. It sits between the host command path and the interconnect's DRT slave, so software and host logic get device base addresses without issuing raw reads.

---
 rtl/drt_lookup_ctrl_if.sv | 46 ++++
 rtl/drt_lookup_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_drt_lookup_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drt_lookup_ctrl_if.sv
// -----------------------------------------------------------------------------
// drt_lookup_ctrl_if
//
// Wishbone classic read bus between the DRT lookup controller (master) and the
// interconnect's device ROM table slave.
//
// Signals:
//   wbm_cyc_o  master -> slave  bus cycle in progress
//   wbm_stb_o  master -> slave  strobe, address valid
//   wbm_we_o   master -> slave  write enable (this master only reads)
//   wbm_adr_o  master -> slave  32-bit word address
//   wbm_dat_o  master -> slave  write data (unused by a read-only master)
//   wbm_dat_i  slave -> master  read data
//   wbm_ack_i  slave -> master  acknowledge
// -----------------------------------------------------------------------------
interface drt_lookup_ctrl_if;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o,
      output wbm_stb_o,
      output wbm_we_o,
      output wbm_adr_o,
      output wbm_dat_o,
      input  wbm_dat_i,
      input  wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o,
      input  wbm_stb_o,
      input  wbm_we_o,
      input  wbm_adr_o,
      input  wbm_dat_o,
      output wbm_dat_i,
      output wbm_ack_i
   );

endinterface : drt_lookup_ctrl_if

// File: rtl/drt_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// drt_lookup_ctrl
//
// Walks the device ROM table (DRT) over Wishbone and looks up one device by
// its 32-bit ID word. The header is read first (ID check, device count), then
// the 4-word device entries are scanned in order. On the first match the
// entry's info, memory offset and size words are fetched.
//
// Parameters:
//   MAX_DEVICES    upper bound on entries scanned (1..255); header count is
//                  clamped to this
//   EXPECT_DRT_ID  required value of header word 0 bits [31:16]
//   TIMEOUT        maximum cycles from strobe rising to acknowledge (1..65535)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   start        single-cycle request, ignored while busy or during done
//   dev_id_i     ID word to match, sampled when start is accepted
//   busy         scan in progress
//   done         one-cycle completion pulse
//   found        match result, held until the next accepted start
//   err_id       header ID mismatch, held until the next accepted start
//   err_timeout  bus access timed out, held until the next accepted start
//   num_devices  raw header word 1 (unclamped)
//   dev_index    0-based index of the matching entry
//   dev_info     entry word 1 of the matching device
//   dev_mem_off  entry word 2 of the matching device
//   dev_size     entry word 3 of the matching device
//   wb           Wishbone master port (read only)
// -----------------------------------------------------------------------------
module drt_lookup_ctrl #(
   parameter int unsigned MAX_DEVICES   = 16,
   parameter logic [15:0] EXPECT_DRT_ID = 16'h0001,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dev_id_i,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic        err_id,
   output logic        err_timeout,
   output logic [31:0] num_devices,
   output logic [7:0]  dev_index,
   output logic [31:0] dev_info,
   output logic [31:0] dev_mem_off,
   output logic [31:0] dev_size,
   drt_lookup_ctrl_if.master wb
);

   typedef enum logic [2:0] {
      IDLE,
      HDR_ID,
      HDR_NUM,
      DEV_ID,
      DEV_INFO,
      DEV_OFF,
      DEV_SIZE,
      FINISH
   } state_e;

   // Bus sub-sequence run by every read state.
   typedef enum logic {
      STB,
      REL
   } phase_e;

   // The counter starts at 0 in the first strobe cycle, so the last waiting
   // cycle before giving up is TIMEOUT-1.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [7:0]  MAX_N    = 8'(MAX_DEVICES);

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [31:0] data_q, data_d;
   logic [31:0] id_q, id_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  n_q, n_d;

   logic        found_d;
   logic        err_id_d;
   logic        err_timeout_d;
   logic [31:0] num_devices_d;
   logic [7:0]  dev_index_d;
   logic [31:0] dev_info_d;
   logic [31:0] dev_mem_off_d;
   logic [31:0] dev_size_d;

   logic        read_state;
   logic [31:0] entry_base;

   assign read_state = (state_q != IDLE) && (state_q != FINISH);
   // Entry i starts at word 4 + 4i; i stays below MAX_DEVICES so no wrap.
   assign entry_base = 32'd4 + {22'd0, idx_q, 2'b00};

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: there is no memory array here; every register has a reset value,
   // so the bus decode drops the moment rst falls, without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         phase_q     <= STB;
         tmo_cnt_q   <= '0;
         data_q      <= '0;
         id_q        <= '0;
         idx_q       <= '0;
         n_q         <= '0;
         found       <= 1'b0;
         err_id      <= 1'b0;
         err_timeout <= 1'b0;
         num_devices <= '0;
         dev_index   <= '0;
         dev_info    <= '0;
         dev_mem_off <= '0;
         dev_size    <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register takes its next
         // value from pre-edge state regardless of statement order.
         state_q     <= state_d;
         phase_q     <= phase_d;
         tmo_cnt_q   <= tmo_cnt_d;
         data_q      <= data_d;
         id_q        <= id_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         found       <= found_d;
         err_id      <= err_id_d;
         err_timeout <= err_timeout_d;
         num_devices <= num_devices_d;
         dev_index   <= dev_index_d;
         dev_info    <= dev_info_d;
         dev_mem_off <= dev_mem_off_d;
         dev_size    <= dev_size_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and datapath
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a hold-value default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d       = state_q;
      phase_d       = phase_q;
      tmo_cnt_d     = tmo_cnt_q;
      data_d        = data_q;
      id_d          = id_q;
      idx_d         = idx_q;
      n_d           = n_q;
      found_d       = found;
      err_id_d      = err_id;
      err_timeout_d = err_timeout;
      num_devices_d = num_devices;
      dev_index_d   = dev_index;
      dev_info_d    = dev_info;
      dev_mem_off_d = dev_mem_off;
      dev_size_d    = dev_size;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               id_d          = dev_id_i;
               idx_d         = '0;
               n_d           = '0;
               found_d       = 1'b0;
               err_id_d      = 1'b0;
               err_timeout_d = 1'b0;
               num_devices_d = '0;
               dev_index_d   = '0;
               dev_info_d    = '0;
               dev_mem_off_d = '0;
               dev_size_d    = '0;
               phase_d       = STB;
               tmo_cnt_d     = '0;
               state_d       = HDR_ID;
            end
         end

         FINISH: begin
            // A start arriving together with done is deliberately dropped.
            state_d = IDLE;
         end

         default: begin
            if (phase_q == STB) begin
               if (wb.wbm_ack_i) begin
                  data_d  = wb.wbm_dat_i;
                  phase_d = REL;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  err_timeout_d = 1'b1;
                  phase_d       = STB;
                  state_d       = FINISH;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 16'd1;
               end
            end else if (!wb.wbm_ack_i) begin
               // Access fully released: act on the word latched at ack time.
               phase_d   = STB;
               tmo_cnt_d = '0;
               case (state_q)
                  HDR_ID: begin
                     if (data_q[31:16] != EXPECT_DRT_ID) begin
                        err_id_d = 1'b1;
                        state_d  = FINISH;
                     end else begin
                        state_d = HDR_NUM;
                     end
                  end
                  HDR_NUM: begin
                     num_devices_d = data_q;
                     n_d           = (data_q > 32'(MAX_DEVICES)) ? MAX_N : data_q[7:0];
                     idx_d         = '0;
                     state_d       = (data_q == '0) ? FINISH : DEV_ID;
                  end
                  DEV_ID: begin
                     if (data_q == id_q) begin
                        dev_index_d = idx_q;
                        state_d     = DEV_INFO;
                     end else if (idx_q + 8'd1 == n_q) begin
                        state_d = FINISH;
                     end else begin
                        idx_d = idx_q + 8'd1;
                     end
                  end
                  DEV_INFO: begin
                     dev_info_d = data_q;
                     state_d    = DEV_OFF;
                  end
                  DEV_OFF: begin
                     dev_mem_off_d = data_q;
                     state_d       = DEV_SIZE;
                  end
                  DEV_SIZE: begin
                     dev_size_d = data_q;
                     found_d    = 1'b1;
                     state_d    = FINISH;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      wb.wbm_cyc_o = read_state;
      wb.wbm_stb_o = read_state && (phase_q == STB);
      wb.wbm_we_o  = 1'b0;
      wb.wbm_dat_o = '0;
      busy         = read_state;
      done         = (state_q == FINISH);

      unique case (state_q)
         HDR_ID:   wb.wbm_adr_o = 32'd0;
         HDR_NUM:  wb.wbm_adr_o = 32'd1;
         DEV_ID:   wb.wbm_adr_o = entry_base;
         DEV_INFO: wb.wbm_adr_o = entry_base + 32'd1;
         DEV_OFF:  wb.wbm_adr_o = entry_base + 32'd2;
         DEV_SIZE: wb.wbm_adr_o = entry_base + 32'd3;
         default:  wb.wbm_adr_o = 32'd0;
      endcase
   end

endmodule : drt_lookup_ctrl

// File: tb/tb_drt_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drt_lookup_ctrl
//
// Directed scoreboard bench for drt_lookup_ctrl. A behavioural DRT slave acks
// one cycle after strobe and releases one cycle after strobe falls. Stimulus
// pushes the expected result of each accepted lookup; the monitor pops and
// compares on every done, and checks all outputs on each reset assertion.
// -----------------------------------------------------------------------------
module tb_drt_lookup_ctrl;

   typedef struct {
      logic        found;
      logic        err_id;
      logic        err_tmo;
      logic [31:0] num;
      logic [31:0] idx;
      logic [31:0] info;
      logic [31:0] off;
      logic [31:0] size;
      logic [31:0] acc;
      logic [31:0] last_adr;
      logic [31:0] delta;
   } exp_t;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        start   = 1'b0;
   logic [31:0] dev_id  = '0;
   logic        busy;
   logic        done;
   logic        found;
   logic        err_id;
   logic        err_timeout;
   logic [31:0] num_devices;
   logic [7:0]  dev_index;
   logic [31:0] dev_info;
   logic [31:0] dev_mem_off;
   logic [31:0] dev_size;

   logic [31:0] mem [128];
   bit          no_ack  = 1'b0;
   bit          end_req = 1'b0;
   int          cyc_no  = 0;
   int          n_pass  = 0;
   int          n_total = 0;
   exp_t        sb [$];

   drt_lookup_ctrl_if wb ();

   drt_lookup_ctrl #(
      .MAX_DEVICES   (16),
      .EXPECT_DRT_ID (16'h0001),
      .TIMEOUT       (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dev_id_i    (dev_id),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .err_id      (err_id),
      .err_timeout (err_timeout),
      .num_devices (num_devices),
      .dev_index   (dev_index),
      .dev_info    (dev_info),
      .dev_mem_off (dev_mem_off),
      .dev_size    (dev_size),
      .wb          (wb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_no <= cyc_no + 1;

   // DRT slave: registered ack and read data.
   initial begin : slave
      wb.wbm_ack_i <= 1'b0;
      wb.wbm_dat_i <= '0;
      forever begin
         @(posedge clk);
         wb.wbm_ack_i <= wb.wbm_cyc_o && wb.wbm_stb_o && !no_ack;
         wb.wbm_dat_i <= mem[wb.wbm_adr_o[6:0]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: actual 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic exp_t mk(input logic f, input logic ei, input logic et,
                               input logic [31:0] num, input logic [31:0] idx,
                               input logic [31:0] info, input logic [31:0] off,
                               input logic [31:0] size, input logic [31:0] acc,
                               input logic [31:0] last_adr, input logic [31:0] delta);
      exp_t e;
      e.found = f;  e.err_id = ei;  e.err_tmo = et;
      e.num = num;  e.idx = idx;    e.info = info;
      e.off = off;  e.size = size;  e.acc = acc;
      e.last_adr = last_adr;        e.delta = delta;
      return e;
   endfunction

   // --------------------------------------------------------------------------
   // Monitor / scoreboard
   // --------------------------------------------------------------------------
   initial begin : monitor
      logic        rst_prev = 1'b1;
      logic        stb_prev = 1'b0;
      int          t_rise   = 0;
      logic [31:0] acc_cnt  = '0;
      logic [31:0] last_adr = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst && rst_prev) begin
            check("rst_cyc",         32'(wb.wbm_cyc_o), 32'd0);
            check("rst_stb",         32'(wb.wbm_stb_o), 32'd0);
            check("rst_busy",        32'(busy),         32'd0);
            check("rst_done",        32'(done),         32'd0);
            check("rst_found",       32'(found),        32'd0);
            check("rst_err_id",      32'(err_id),       32'd0);
            check("rst_err_timeout", 32'(err_timeout),  32'd0);
            check("rst_num_devices", num_devices,       32'd0);
            check("rst_dev_index",   32'(dev_index),    32'd0);
            check("rst_dev_info",    dev_info,          32'd0);
            check("rst_dev_mem_off", dev_mem_off,       32'd0);
            check("rst_dev_size",    dev_size,          32'd0);
         end
         rst_prev = rst;

         if (rst && start && !busy && !done) acc_cnt = '0;
         if (wb.wbm_stb_o && !stb_prev) begin
            acc_cnt  = acc_cnt + 32'd1;
            last_adr = wb.wbm_adr_o;
            t_rise   = cyc_no;
         end
         stb_prev = wb.wbm_stb_o;

         if (done) begin
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("busy_at_done", 32'(busy),         32'd0);
               check("cyc_at_done",  32'(wb.wbm_cyc_o), 32'd0);
               check("stb_at_done",  32'(wb.wbm_stb_o), 32'd0);
               check("we_tied",      32'(wb.wbm_we_o),  32'd0);
               check("found",        32'(found),        32'(e.found));
               check("err_id",       32'(err_id),       32'(e.err_id));
               check("err_timeout",  32'(err_timeout),  32'(e.err_tmo));
               check("num_devices",  num_devices,       e.num);
               check("dev_index",    32'(dev_index),    e.idx);
               check("dev_info",     dev_info,          e.info);
               check("dev_mem_off",  dev_mem_off,       e.off);
               check("dev_size",     dev_size,          e.size);
               check("accesses",     acc_cnt,           e.acc);
               check("last_adr",     last_adr,          e.last_adr);
               check("stb_to_done",  32'(cyc_no - t_rise), e.delta);
            end
         end

         if (end_req) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, pass %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   task automatic issue(input logic [31:0] id, input exp_t e, input bit push);
      @(posedge clk);
      #1;
      start  = 1'b1;
      dev_id = id;
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !busy && !done) break;
      end
   endtask

   initial begin : stim
      for (int i = 0; i < 128; i++) mem[i] = '0;
      mem[0]  = 32'h0001_0001;  mem[1]  = 32'd2;
      mem[4]  = 32'h0003_0000;  mem[5]  = 32'h11;    mem[6]  = 32'h22;   mem[7]  = 32'h33;
      mem[8]  = 32'h0002_0000;  mem[9]  = 32'hAA;    mem[10] = 32'h1000; mem[11] = 32'h200;
      mem[12] = 32'h0003_0000;  mem[13] = 32'h44;    mem[14] = 32'h55;   mem[15] = 32'h66;

      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Match on entry 1; a start during the scan must be ignored.
      issue(32'h0002_0000, mk(1, 0, 0, 2, 1, 32'hAA, 32'h1000, 32'h200, 7, 11, 4), 1'b1);
      repeat (6) @(posedge clk);
      #1;
      start  = 1'b1;
      dev_id = 32'h0003_0000;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();

      // No match, then a start coincident with done (ignored) followed by
      // one in the next cycle (accepted) that hits the first of two duplicates.
      issue(32'hDEAD_BEEF, mk(0, 0, 0, 2, 0, 0, 0, 0, 4, 8, 4), 1'b1);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
      mem[1] = 32'd3;
      start  = 1'b1;
      dev_id = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      dev_id = 32'h0003_0000;
      sb.push_back(mk(1, 0, 0, 3, 0, 32'h11, 32'h22, 32'h33, 6, 7, 4));
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();

      // Header ID mismatch.
      mem[0] = 32'h0005_0001;
      issue(32'h0002_0000, mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4), 1'b1);
      wait_idle();
      mem[0] = 32'h0001_0001;

      // Zero device count.
      mem[1] = 32'd0;
      issue(32'h0002_0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 4), 1'b1);
      wait_idle();

      // Count clamped to 16; entry 16 holds the ID and must not be reached.
      mem[1]  = 32'h100;
      mem[68] = 32'hDEAD_BEEF;
      issue(32'hDEAD_BEEF, mk(0, 0, 0, 32'h100, 0, 0, 0, 0, 18, 32'h40, 4), 1'b1);
      wait_idle();
      mem[1]  = 32'd2;
      mem[68] = '0;

      // Slave never acks.
      no_ack = 1'b1;
      issue(32'h0002_0000, mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8), 1'b1);
      wait_idle();
      no_ack = 1'b0;

      // Reset asserted between edges while in DEV_ID.
      issue(32'h0002_0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wb.wbm_stb_o && wb.wbm_adr_o == 32'd4) break;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Normal lookup after reset.
      issue(32'h0002_0000, mk(1, 0, 0, 2, 1, 32'hAA, 32'h1000, 32'h200, 7, 11, 4), 1'b1);
      wait_idle();

      repeat (2) @(posedge clk);
      #1 end_req = 1'b1;
   end

endmodule : tb_drt_lookup_ctrl
